line_mem_responder: RTL



---
 rtl/line_mem_responder_pkg.sv | 21 ++
 rtl/line_mem_responder_mem_req_arbiter.sv | 46 ++++
 rtl/line_mem_responder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared definitions for the cache line responder: FSM state encodings,
// line geometry and requester identifiers.
package line_mem_responder_pkg;

  typedef enum logic [1:0] {
    MR_IDLE_STATE = 2'd0,
    MR_BEAT_STATE = 2'd1,
    MR_RESP_STATE = 2'd2
  } mr_state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int BEAT_W         = 2;
  localparam int LINE_W         = 128;
  localparam int WORD_W         = 32;

  typedef enum logic {
    GRANT_ICACHE = 1'b0,
    GRANT_DCACHE = 1'b1
  } grant_e;

endpackage

// File: rtl/line_mem_responder_mem_req_arbiter.sv
// Two-input round-robin arbiter between icache and dcache requesters.
// The last_grant register only moves when the caller accepts a grant, so a
// request that is seen but not taken does not disturb fairness.
module mem_req_arbiter
  import line_mem_responder_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   i_req,
  input  logic   d_req,
  input  logic   accept,
  output logic   gnt_valid,
  output grant_e gnt_id
);

  grant_e last_q, last_d;

  // Pick the winner; on contention favour the side not granted last.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the branches can leave a value unassigned and infer a latch.
    gnt_valid = i_req | d_req;
    gnt_id    = GRANT_ICACHE;
    last_d    = last_q;
    if (i_req && d_req) begin
      gnt_id = (last_q == GRANT_ICACHE) ? GRANT_DCACHE : GRANT_ICACHE;
    end else if (d_req) begin
      gnt_id = GRANT_DCACHE;
    end
    if (accept && gnt_valid) begin
      last_d = gnt_id;
    end
  end

  // last_grant register; starts at icache so dcache wins the first tie.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      last_q <= GRANT_ICACHE;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side responder for the icache/dcache line refill/write-back ports.
// Each 128-bit line transfer is split into four 32-bit beats on a
// single-outstanding external word bus; reads are reassembled and returned
// as one line with a one-cycle ready pulse.
// Optional build macro MEMRESP_TIMEOUT_EN adds an ext_ack watchdog and a
// sticky err output.
module line_mem_responder
  import line_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = 20,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [LINE_W-1:0]   i_wdata,
  output logic                i_ready,
  output logic [LINE_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [LINE_W-1:0]   d_wdata,
  output logic                d_ready,
  output logic [LINE_W-1:0]   d_rdata,
  output logic                ext_valid,
  output logic                ext_we,
  output logic [ADDR_W-1:0]   ext_addr,
  output logic [WORD_W-1:0]   ext_wdata,
  input  logic [WORD_W-1:0]   ext_rdata,
  input  logic                ext_ack,
  output logic                busy
`ifdef MEMRESP_TIMEOUT_EN
  ,
  output logic                err
`endif
);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

  mr_state_e           state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                we_q, we_d;
  logic [ADDR_W-3:0]   base_q, base_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic [LINE_W-1:0]   buf_q, buf_d;
  grant_e              gnt_q, gnt_d;

  logic                arb_valid;
  grant_e              arb_id;
  logic                accept;
  logic                resp_state;
  logic                zero_line;
  logic [LINE_W-1:0]   resp_line;

  // Line addresses are always line-aligned; the low word bits are dropped.
  logic                unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

`ifdef MEMRESP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0]    wdog_q, wdog_d;
  logic                err_q, err_d;
  logic                tout_q, tout_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  mem_req_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .i_req     (i_req),
    .d_req     (d_req),
    .accept    (accept),
    .gnt_valid (arb_valid),
    .gnt_id    (arb_id)
  );

  // Next-state logic and external beat outputs.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    we_d      = we_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    buf_d     = buf_q;
    gnt_d     = gnt_q;
    accept    = 1'b0;
    ext_valid = 1'b0;
    ext_we    = 1'b0;
    ext_addr  = '0;
    ext_wdata = '0;
`ifdef MEMRESP_TIMEOUT_EN
    wdog_d    = wdog_q;
    err_d     = err_q;
    tout_d    = tout_q;
`endif
    unique case (state_q)
      MR_IDLE_STATE: begin
        if (arb_valid) begin
          accept  = 1'b1;
          gnt_d   = arb_id;
          beat_d  = '0;
          state_d = MR_BEAT_STATE;
          if (arb_id == GRANT_DCACHE) begin
            we_d    = d_we;
            base_d  = d_addr[ADDR_W-1:2];
            wdata_d = d_wdata;
          end else begin
            we_d    = i_we;
            base_d  = i_addr[ADDR_W-1:2];
            wdata_d = i_wdata;
          end
`ifdef MEMRESP_TIMEOUT_EN
          wdog_d = '0;
          tout_d = 1'b0;
`endif
        end
      end

      MR_BEAT_STATE: begin
        // Beat offset lives in the two low address bits only, so the
        // line base never carries.
        ext_valid = 1'b1;
        ext_we    = we_q;
        ext_addr  = {base_q, beat_q};
        ext_wdata = wdata_q[{beat_q, 5'd0} +: WORD_W];
        if (ext_ack) begin
          if (!we_q) begin
            buf_d[{beat_q, 5'd0} +: WORD_W] = ext_rdata;
          end
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = MR_RESP_STATE;
          end
`ifdef MEMRESP_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_q == WDOG_LAST) begin
          state_d = MR_RESP_STATE;
          err_d   = 1'b1;
          tout_d  = 1'b1;
        end else begin
          wdog_d = wdog_q + 1'b1;
`endif
        end
      end

      MR_RESP_STATE: begin
        state_d = MR_IDLE_STATE;
      end

      default: begin
        state_d = MR_IDLE_STATE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MR_IDLE_STATE;
      beat_q  <= '0;
      we_q    <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      // NOTE: the line buffer is a flop bank, not a RAM macro, so it is reset
      // like any other register and rdata is defined from the first cycle.
      buf_q   <= '0;
      gnt_q   <= GRANT_ICACHE;
`ifdef MEMRESP_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      gnt_q   <= gnt_d;
`ifdef MEMRESP_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
      tout_q  <= tout_d;
`endif
    end
  end

  // Completion: pulse only the granted side, and only if it still wants it.
  assign resp_state = (state_q == MR_RESP_STATE);
`ifdef MEMRESP_TIMEOUT_EN
  assign zero_line  = we_q | tout_q;
  assign err        = err_q;
`else
  assign zero_line  = we_q;
`endif
  assign resp_line  = zero_line ? '0 : buf_q;
  assign i_ready    = resp_state && (gnt_q == GRANT_ICACHE) && i_req;
  assign d_ready    = resp_state && (gnt_q == GRANT_DCACHE) && d_req;
  assign i_rdata    = i_ready ? resp_line : '0;
  assign d_rdata    = d_ready ? resp_line : '0;
  assign busy       = (state_q != MR_IDLE_STATE);

endmodule
